// File: rtl/seq_match_fsm.sv
// Parametrised sequence detector: pulses q when the last DEPTH accepted symbols equal PATTERN.
// Define SEQ_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_match_fsm #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 3,
    parameter logic [DEPTH*SYM_W-1:0] PATTERN = 6'b000110,
    parameter int CNT_W = 8,
    localparam int ST_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             q,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] match_cnt
);

    logic [(DEPTH-1)*SYM_W-1:0] hist_reg;
    logic [ST_W-1:0]            fill_reg;
    logic [ST_W-1:0]            state_reg;
    logic                       q_reg;

    logic [DEPTH*SYM_W-1:0]     window;
    logic [DEPTH-1:0]           match_vec;
    logic [ST_W-1:0]            prefix_len;
    logic                       full_hit;

    // Symbol 0 of the window is the newest one; older symbols sit at higher indices.
    assign window = {hist_reg, sym};

    // match_vec[gi-1]: the newest gi window symbols equal PATTERN symbols 0..gi-1.
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_prefix
        logic same;
        always_comb begin
            same = 1'b1;
            for (int j = 0; j < gi; j++) begin
                if (window[SYM_W*j +: SYM_W] != PATTERN[SYM_W*(gi-1-j) +: SYM_W])
                    same = 1'b0;
            end
        end
        assign match_vec[gi-1] = same && (int'(fill_reg) >= gi - 1);
    end

    // Longest proper prefix serves both the mismatch fallback and the overlapped restart.
    always_comb begin
        prefix_len = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (match_vec[k-1])
                prefix_len = ST_W'(k);
        end
    end

    assign full_hit = match_vec[DEPTH-1];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            state_reg <= '0;
            q_reg     <= 1'b0;
        end else begin
            q_reg <= sym_valid && full_hit;
            if (sym_valid) begin
                hist_reg <= window[(DEPTH-1)*SYM_W-1:0];
                if (full_hit && !overlap) begin
                    state_reg <= '0;
                    fill_reg  <= '0;
                end else begin
                    state_reg <= prefix_len;
                    fill_reg  <= (fill_reg == ST_W'(DEPTH-1)) ? fill_reg : fill_reg + 1'b1;
                end
            end
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (sym_valid && full_hit && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign match_cnt = cnt_reg;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
`endif

    assign q     = q_reg;
    assign state = state_reg;

endmodule

// File: doc/seq_match_fsm.md
# seq_match_fsm

Parametrised sequence-recognition FSM for the control-path family of small Moore/Mealy detectors. It watches a stream of SYM_W-bit input symbols and pulses `q` when the last DEPTH accepted symbols equal a compile-time PATTERN. It generalises the fixed 4-state x/y detector to any symbol width and sequence depth, and adds:
- a valid qualifier,
- an overlapping/non-overlapping match mode,
- a saturating match counter.

## Interface
Parameters:
- SYM_W, 2 — symbol width; default symbol is {x,y}.
- DEPTH, 3 — pattern length in symbols, legal 2..8.
- PATTERN, 6'b000110 — DEPTH*SYM_W bits; symbol i = PATTERN[SYM_W*i +: SYM_W], symbol 0 received first. Default sequence: 2'b10, 2'b01, 2'b00 (SA->SB->SC->SD).
- CNT_W, 8 — match counter width.
- Localparam ST_W = $clog2(DEPTH).

Ports:
- Clk  in  1 — clock, rising edge.
- Rst  in  1 — synchronous, active-low reset; sampled on rising Clk.
- sym_valid  in  1 — symbol on `sym` is accepted this edge.
- sym  in  SYM_W — input symbol.
- overlap  in  1 — 1 = overlapping matches allowed; 0 = restart after match.
- clr_cnt  in  1 — synchronous clear of match_cnt.
- q  out  1 — one-cycle match pulse, registered.
- state  out  ST_W — number of pattern symbols currently matched (0..DEPTH-1).
- match_cnt  out  CNT_W — saturating count of matches.

## Operation
- Reset (Rst==0 at an edge): state=0, q=0, match_cnt=0, history register cleared. Reset overrides all other inputs.
- History: shift register of the last DEPTH-1 accepted symbols, plus a count of valid entries (for prefix checks).
- On an edge with sym_valid=1:
  - Candidate window = history plus new `sym`.
  - k = largest value in 1..DEPTH such that the last k symbols of the window equal PATTERN symbols 0..k-1; 0 if none.
  - If k < DEPTH: state <= k, q <= 0.
  - If k == DEPTH: match. q <= 1, match_cnt increments.
    - overlap=1: state <= longest proper prefix of PATTERN that is also a suffix of the window; history is kept.
    - overlap=0: state <= 0; history valid count cleared.
- sym_valid=0: state and history hold, q <= 0, match_cnt holds.
- Mismatch never blindly returns to 0; it falls back to the longest matching prefix. Example with the default pattern: 10,10 gives state 1, not 0.
- Counter:
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 forces match_cnt <= 0. This takes priority over a same-edge increment; q still pulses.
- `overlap` is sampled only on the match edge. Changing it mid-sequence is legal.

## Timing
- Match latency: q is high for exactly one Clk cycle, starting at the edge that accepts the final pattern symbol.
- match_cnt updates on the same edge as q rises.
- Back-to-back matches are possible with overlap=1 and a self-overlapping PATTERN. q then stays high for consecutive cycles, one per match.
- `state` is registered and is valid one edge after the symbol is accepted.
- Reset mid-sequence: the next accepted symbol is compared against PATTERN symbol 0 only. No partial match survives reset.
- Inputs must be stable for setup before the rising edge. The bench drives inputs 50 ns after posedge with a 200 ns clock period.

## Configuration
- SEQ_MATCH_CNT_EN defined: the match counter and clr_cnt logic are compiled in, as described above.
- SEQ_MATCH_CNT_EN undefined:
  - No counter flops.
  - match_cnt is tied to 0.
  - clr_cnt is ignored.
  - The port list is unchanged.
  - q and state behaviour are identical.

## Test plan
- Reset: hold Rst=0 for 2 edges with random sym/sym_valid -> q=0, state=0, match_cnt=0.
- Default pattern: Rst=1; on successive edges drive sym = 10, 01, 00 (valid=1) -> state 1, 2, then q=1 for one cycle, state=0, match_cnt=1.
- Fallback and gaps: sym = 10, 10, [valid=0 for 3 cycles], 01, 00 -> state 1, 1, held at 1, then 2, then q pulse; match_cnt=1.
- Overlap: instance with PATTERN = 10,10,10, overlap=1, feed five 10s -> q high on symbols 3, 4 and 5, match_cnt=3. Same stimulus with overlap=0 -> single pulse on symbol 3, state=2 after symbol 5.
- Reset mid-operation: 10, 01, then Rst=0 for one edge, then 00 -> no q pulse, state=0.
- Counter (CNT_W=2, macro defined): 5 matches -> match_cnt saturates at 3. Assert clr_cnt on the edge of the 6th match -> q=1 and match_cnt=0. Without the macro: match_cnt stays 0 throughout.
